// File: rtl/wb_retire_buffer.sv
// Write-back retire buffer: selects the write-back value, queues retiring results in a FIFO,
// drains one per granted cycle into the regfile and maintains the nzp condition codes.
module wb_retire_buffer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NSRC     = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned REG_BITS = 3,
    localparam int unsigned SELW    = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int unsigned CNTW    = $clog2(DEPTH) + 1,
    localparam int unsigned NREG    = 2 ** REG_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NSRC*WIDTH-1:0] in_src,
    input  logic [SELW-1:0]       in_sel,
    input  logic [REG_BITS-1:0]   in_dr,
    input  logic                  in_ld_reg,
    input  logic                  in_ld_cc,
    input  logic                  flush,
    input  logic                  rf_grant,
    output logic [WIDTH-1:0]      reg_data,
    output logic [REG_BITS-1:0]   dest_reg,
    output logic                  ld_reg_store,
    output logic [2:0]            gencc_out,
    output logic [NREG-1:0]       pending_mask,
    output logic [CNTW-1:0]       count
);

    localparam int unsigned PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0]    data_q  [DEPTH];
    logic [WIDTH-1:0]    data_d  [DEPTH];
    logic [REG_BITS-1:0] dr_q    [DEPTH];
    logic [REG_BITS-1:0] dr_d    [DEPTH];
    logic [DEPTH-1:0]    ldreg_q, ldreg_d;
    logic [DEPTH-1:0]    ldcc_q, ldcc_d;
    logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic [2:0]          cc_q, cc_d;

    logic             full;
    logic             head_valid;
    logic             accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] head_data;

    assign full       = (count_q == CNTW'(DEPTH));
    assign head_valid = (count_q != '0);
    assign in_ready   = !full;
    assign accept     = in_valid && in_ready && !flush;
    // No-op retires are handshaken but never occupy a slot.
    assign push       = accept && (in_ld_reg || in_ld_cc);
    assign pop        = head_valid && rf_grant && !flush;
    assign head_data  = data_q[rd_ptr_q];

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (32'(in_sel) == k) begin
                sel_data = in_src[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        data_d   = data_q;
        dr_d     = dr_q;
        ldreg_d  = ldreg_q;
        ldcc_d   = ldcc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cc_d     = cc_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q]  = sel_data;
                dr_d[wr_ptr_q]    = in_dr;
                ldreg_d[wr_ptr_q] = in_ld_reg;
                ldcc_d[wr_ptr_q]  = in_ld_cc;
                wr_ptr_d          = wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
                if (ldcc_q[rd_ptr_q]) begin
                    if (head_data[WIDTH-1]) begin
                        cc_d = 3'b100;
                    end else if (head_data == '0) begin
                        cc_d = 3'b010;
                    end else begin
                        cc_d = 3'b001;
                    end
                end
            end
            count_d = count_q + CNTW'(push) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                dr_q[i]   <= '0;
            end
            ldreg_q  <= '0;
            ldcc_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cc_q     <= 3'b010;
        end else begin
            data_q   <= data_d;
            dr_q     <= dr_d;
            ldreg_q  <= ldreg_d;
            ldcc_q   <= ldcc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cc_q     <= cc_d;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PTRW-1:0] off;
        pending_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off = PTRW'(i) - rd_ptr_q;
            if ((CNTW'(off) < count_q) && ldreg_q[i]) begin
                pending_mask[dr_q[i]] = 1'b1;
            end
        end
    end

    assign reg_data     = head_valid ? head_data : '0;
    assign dest_reg     = head_valid ? dr_q[rd_ptr_q] : '0;
    assign ld_reg_store = pop && ldreg_q[rd_ptr_q];
    assign gencc_out    = cc_q;
    assign count        = count_q;

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Self-checking bench for wb_retire_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_retire_buffer;

    localparam int WIDTH = 16;
    localparam int NSRC  = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_src;
    logic [1:0]  in_sel;
    logic [2:0]  in_dr;
    logic        in_ld_reg;
    logic        in_ld_cc;
    logic        flush;
    logic        rf_grant;
    logic [15:0] reg_data;
    logic [2:0]  dest_reg;
    logic        ld_reg_store;
    logic [2:0]  gencc_out;
    logic [7:0]  pending_mask;
    logic [2:0]  count;

    int errs;
    int checks;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  dr;
        logic        ldr;
        logic        ldc;
    } ent_t;

    ent_t       mq[$];
    logic [2:0] mcc;

    wb_retire_buffer #(
        .WIDTH    (WIDTH),
        .NSRC     (NSRC),
        .DEPTH    (DEPTH),
        .REG_BITS (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_src       (in_src),
        .in_sel       (in_sel),
        .in_dr        (in_dr),
        .in_ld_reg    (in_ld_reg),
        .in_ld_cc     (in_ld_cc),
        .flush        (flush),
        .rf_grant     (rf_grant),
        .reg_data     (reg_data),
        .dest_reg     (dest_reg),
        .ld_reg_store (ld_reg_store),
        .gencc_out    (gencc_out),
        .pending_mask (pending_mask),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'h0) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [7:0] model_mask();
        logic [7:0] m = '0;
        foreach (mq[i]) if (mq[i].ldr) m[mq[i].dr] = 1'b1;
        return m;
    endfunction

    // Advance the reference model by one clock using the currently driven inputs.
    task automatic model_step();
        ent_t e;
        bit   acc;
        if (flush) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            if (mq.size() > 0 && rf_grant) begin
                e = mq.pop_front();
                if (e.ldc) mcc = cc_of(e.data);
            end
            if (acc && (in_ld_reg || in_ld_cc)) begin
                e.data = in_src[in_sel*16 +: 16];
                e.dr   = in_dr;
                e.ldr  = in_ld_reg;
                e.ldc  = in_ld_cc;
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_src    = '0;
        in_sel    = '0;
        in_dr     = '0;
        in_ld_reg = 1'b0;
        in_ld_cc  = 1'b0;
        flush     = 1'b0;
        rf_grant  = 1'b0;
    endtask

    task automatic drive_push(input logic [15:0] v, input logic [1:0] sel, input logic [2:0] dr,
                              input logic ldr, input logic ldc);
        in_valid              = 1'b1;
        in_src                = {$urandom, $urandom};
        in_sel                = sel;
        in_src[sel*16 +: 16]  = v;
        in_dr                 = dr;
        in_ld_reg             = ldr;
        in_ld_cc              = ldc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        mq.delete();
        mcc = 3'b010;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        checks++; if (ld_reg_store !== 1'b0) begin errs++; $display("FAIL reset_store got=%b want=0", ld_reg_store); end
        checks++; if (pending_mask !== 8'h00) begin errs++; $display("FAIL reset_mask got=%h want=00", pending_mask); end
        checks++; if (gencc_out !== 3'b010) begin errs++; $display("FAIL reset_cc got=%b want=010", gencc_out); end
        checks++; if (reg_data !== 16'h0 || dest_reg !== 3'd0) begin
            errs++; $display("FAIL reset_head got=%h/%0d want=0000/0", reg_data, dest_reg);
        end
    endtask

    task automatic test_single();
        rf_grant = 1'b1;
        drive_push(16'h8000, 2'd3, 3'd5, 1'b1, 1'b1);
        #1;
        checks++; if (ld_reg_store !== 1'b0) begin errs++; $display("FAIL single_bypass got=%b want=0", ld_reg_store); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (ld_reg_store !== 1'b1) begin errs++; $display("FAIL single_store got=%b want=1", ld_reg_store); end
        checks++; if (reg_data !== 16'h8000) begin errs++; $display("FAIL single_data got=%h want=8000", reg_data); end
        checks++; if (dest_reg !== 3'd5) begin errs++; $display("FAIL single_dr got=%0d want=5", dest_reg); end
        tick();
        checks++; if (gencc_out !== 3'b100) begin errs++; $display("FAIL single_cc got=%b want=100", gencc_out); end
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL single_count got=%0d want=0", count); end
        rf_grant = 1'b0;
    endtask

    task automatic test_full();
        logic [15:0] vals[4];
        rf_grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vals[k] = 16'($urandom);
            drive_push(vals[k], 2'($urandom_range(0, 3)), 3'(k + 1), 1'b1, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL full_ready got=%b want=0", in_ready); end
        checks++; if (pending_mask !== 8'b0001_1110) begin errs++; $display("FAIL full_mask got=%b want=00011110", pending_mask); end
        drive_push(16'h1234, 2'd0, 3'd7, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin errs++; $display("FAIL full_refuse_count got=%0d want=4", count); end
        checks++; if (pending_mask[7] !== 1'b0) begin errs++; $display("FAIL full_refuse_mask got=%b want=0", pending_mask[7]); end
        rf_grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (dest_reg !== 3'(k + 1) || reg_data !== vals[k] || ld_reg_store !== 1'b1) begin
                errs++; $display("FAIL full_drain%0d got=%0d/%h/%b want=%0d/%h/1", k, dest_reg, reg_data, ld_reg_store, k + 1, vals[k]);
            end
            tick();
        end
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL full_empty got=%0d want=0", count); end
        rf_grant = 1'b0;
    endtask

    task automatic test_cc_only();
        rf_grant = 1'b0;
        drive_push(16'h0000, 2'd0, 3'd2, 1'b0, 1'b1);
        tick();
        drive_push(16'h0001, 2'd1, 3'd6, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (pending_mask !== 8'b0100_0000) begin errs++; $display("FAIL cc_mask got=%b want=01000000", pending_mask); end
        rf_grant = 1'b1;
        #1;
        checks++; if (ld_reg_store !== 1'b0) begin errs++; $display("FAIL cc_store1 got=%b want=0", ld_reg_store); end
        tick();
        checks++; if (gencc_out !== 3'b010) begin errs++; $display("FAIL cc_after1 got=%b want=010", gencc_out); end
        checks++; if (ld_reg_store !== 1'b1 || reg_data !== 16'h0001) begin
            errs++; $display("FAIL cc_store2 got=%b/%h want=1/0001", ld_reg_store, reg_data);
        end
        tick();
        checks++; if (gencc_out !== 3'b010) begin errs++; $display("FAIL cc_after2 got=%b want=010", gencc_out); end
        rf_grant = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q[$];
        logic [15:0] v;
        rf_grant = 1'b0;
        for (int k = 0; k < 2; k++) begin
            v = 16'($urandom);
            exp_q.push_back(v);
            drive_push(v, 2'($urandom_range(0, 3)), 3'($urandom), 1'b1, 1'b1);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            v = 16'($urandom);
            drive_push(v, 2'($urandom_range(0, 3)), 3'($urandom), 1'b1, 1'b1);
            rf_grant = 1'b1;
            #1;
            checks++; if (reg_data !== exp_q[0] || count !== 3'd2) begin
                errs++; $display("FAIL b2b%0d got=%h/%0d want=%h/2", k, reg_data, count, exp_q[0]);
            end
            void'(exp_q.pop_front());
            exp_q.push_back(v);
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (count !== 3'd2 || reg_data !== exp_q[0]) begin
            errs++; $display("FAIL b2b_end got=%h/%0d want=%h/2", reg_data, count, exp_q[0]);
        end
    endtask

    task automatic test_flush();
        rf_grant = 1'b0;
        drive_push(16'h7fff, 2'd2, 3'd0, 1'b1, 1'b1);
        tick();
        checks++; if (count !== 3'd3) begin errs++; $display("FAIL flush_occ got=%0d want=3", count); end
        drive_push(16'h8001, 2'd1, 3'd3, 1'b1, 1'b1);
        flush    = 1'b1;
        rf_grant = 1'b1;
        #1;
        checks++; if (ld_reg_store !== 1'b0) begin errs++; $display("FAIL flush_store got=%b want=0", ld_reg_store); end
        tick();
        idle_inputs();
        #1;
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL flush_count got=%0d want=0", count); end
        checks++; if (pending_mask !== 8'h00) begin errs++; $display("FAIL flush_mask got=%h want=00", pending_mask); end
        checks++; if (gencc_out !== mcc) begin errs++; $display("FAIL flush_cc got=%b want=%b", gencc_out, mcc); end
    endtask

    task automatic test_reset_mid();
        rf_grant = 1'b0;
        drive_push(16'hc000, 2'd0, 3'd1, 1'b1, 1'b1);
        tick();
        drive_push(16'h0005, 2'd1, 3'd2, 1'b1, 1'b1);
        tick();
        drive_push(16'h0006, 2'd2, 3'd3, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        rf_grant = 1'b1;
        tick();
        checks++; if (count !== 3'd2 || gencc_out !== 3'b100) begin
            errs++; $display("FAIL mid_pre got=%0d/%b want=2/100", count, gencc_out);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL mid_count got=%0d want=0", count); end
        checks++; if (ld_reg_store !== 1'b0) begin errs++; $display("FAIL mid_store got=%b want=0", ld_reg_store); end
        checks++; if (gencc_out !== 3'b010) begin errs++; $display("FAIL mid_cc got=%b want=010", gencc_out); end
        @(posedge clk);
        #1;
        checks++; if (count !== 3'd0 || gencc_out !== 3'b010) begin
            errs++; $display("FAIL mid_held got=%0d/%b want=0/010", count, gencc_out);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [15:0] exp_data;
        logic [2:0]  exp_dr;
        logic        exp_store;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_src    = {$urandom, $urandom};
            in_sel    = 2'($urandom);
            in_dr     = 3'($urandom);
            in_ld_reg = ($urandom_range(0, 3) != 0);
            in_ld_cc  = ($urandom_range(0, 2) == 0);
            rf_grant  = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) in_src[in_sel*16 +: 16] = 16'h0;
            #1;
            exp_data  = (mq.size() > 0) ? mq[0].data : 16'h0;
            exp_dr    = (mq.size() > 0) ? mq[0].dr : 3'd0;
            exp_store = (mq.size() > 0) && mq[0].ldr && rf_grant && !flush;
            checks++; if (count !== 3'(mq.size()) || in_ready !== (mq.size() < DEPTH)) begin
                errs++; $display("FAIL rnd_count c=%0d got=%0d/%b want=%0d", c, count, in_ready, mq.size());
            end
            checks++; if (reg_data !== exp_data || dest_reg !== exp_dr) begin
                errs++; $display("FAIL rnd_head c=%0d got=%h/%0d want=%h/%0d", c, reg_data, dest_reg, exp_data, exp_dr);
            end
            checks++; if (ld_reg_store !== exp_store) begin
                errs++; $display("FAIL rnd_store c=%0d got=%b want=%b", c, ld_reg_store, exp_store);
            end
            checks++; if (pending_mask !== model_mask()) begin
                errs++; $display("FAIL rnd_mask c=%0d got=%b want=%b", c, pending_mask, model_mask());
            end
            checks++; if (gencc_out !== mcc) begin
                errs++; $display("FAIL rnd_cc c=%0d got=%b want=%b", c, gencc_out, mcc);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_single();
        test_full();
        test_cc_only();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
